// File: rtl/ahb_dma_master.sv
// AHB-Lite write master for the RCC-programmed DMA fill: descending word addresses, ascending data.
// Latency: NONSEQ on the bus the cycle after start is accepted; done one cycle after the last data phase.
// Backpressure: HREADY low holds the whole bus; `DMA_ERR_ABORT_EN enables abort on an HRESP error.
module ahb_dma_master (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic [5:0]  RCC_Words_N,
    input  logic [15:0] RCC_DMA_ADDR_HIGH,
    input  logic [15:0] RCC_DMA_ADDR_LOW,
    input  logic [31:0] init_data,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_BURST = 2'd2,
        S_LAST  = 2'd3
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_haddr;
    logic [31:0] r_data;
    logic [1:0]  r_htrans;
    logic [31:0] r_hwdata;
    logic        r_done;
    logic        r_err;

    state_t      w_state_nxt;
    logic [5:0]  w_cnt_nxt;
    logic [31:0] w_haddr_nxt;
    logic [31:0] w_data_nxt;
    logic [1:0]  w_htrans_nxt;
    logic [31:0] w_hwdata_nxt;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic        w_abort;

    // An error can only be reported while a data phase is outstanding (BURST or LAST).
`ifdef DMA_ERR_ABORT_EN
    assign w_abort = ((r_state == S_BURST) || (r_state == S_LAST)) && HRESP && !HREADY;
`else
    logic w_unused_hresp;
    assign w_unused_hresp = HRESP;
    assign w_abort        = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt    <= 6'd0;
            r_haddr  <= 32'd0;
            r_data   <= 32'd0;
            r_htrans <= HT_IDLE;
            r_hwdata <= 32'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_haddr  <= w_haddr_nxt;
            r_data   <= w_data_nxt;
            r_htrans <= w_htrans_nxt;
            r_hwdata <= w_hwdata_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_haddr_nxt  = r_haddr;
        w_data_nxt   = r_data;
        w_htrans_nxt = r_htrans;
        w_hwdata_nxt = r_hwdata;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;

        if (w_abort) begin
            w_state_nxt  = S_IDLE;
            w_htrans_nxt = HT_IDLE;
            w_cnt_nxt    = 6'd0;
            w_err_nxt    = 1'b1;
            w_done_nxt   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_err_nxt = 1'b0;
                        if (RCC_Words_N != 6'd0) begin
                            w_state_nxt  = S_FIRST;
                            w_cnt_nxt    = RCC_Words_N;
                            w_haddr_nxt  = {RCC_DMA_ADDR_HIGH, RCC_DMA_ADDR_LOW};
                            w_data_nxt   = init_data;
                            w_htrans_nxt = HT_NONSEQ;
                        end else begin
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                S_FIRST, S_BURST: begin
                    // Address phase accepted: its data moves to the data phase next cycle.
                    if (HREADY) begin
                        w_hwdata_nxt = r_data;
                        w_data_nxt   = r_data + 32'd1;
                        w_cnt_nxt    = r_cnt - 6'd1;
                        if (r_cnt == 6'd1) begin
                            w_state_nxt  = S_LAST;
                            w_htrans_nxt = HT_IDLE;
                        end else begin
                            w_state_nxt  = S_BURST;
                            w_haddr_nxt  = r_haddr - 32'd1;
                            w_htrans_nxt = HT_SEQ;
                        end
                    end
                end
                S_LAST: begin
                    if (HREADY) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_htrans_nxt = HT_IDLE;
                end
            endcase
        end
    end

    assign HADDR  = r_haddr;
    assign HTRANS = r_htrans;
    assign HWRITE = (r_htrans != HT_IDLE);
    assign HSIZE  = 3'b010;
    assign HBURST = 3'b001;
    assign HWDATA = r_hwdata;
    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign err    = r_err;

endmodule
